// File: rtl/ase_pkg.sv
// Shared ASE CCI-P emulator types: config-header field widths and the
// MMIO read tracking entry used by the read-response tracker.
package ase_pkg;

  localparam int CCIP_CFGHDR_TID_WIDTH   = 9;
  localparam int CCIP_CFGHDR_INDEX_WIDTH = 16;
  localparam int CCIP_MMIO_DATA_WIDTH    = 64;

  typedef logic [CCIP_CFGHDR_TID_WIDTH-1:0]   ccip_tid_t;
  typedef logic [CCIP_CFGHDR_INDEX_WIDTH-1:0] ccip_index_t;
  typedef logic [CCIP_MMIO_DATA_WIDTH-1:0]    ccip_mmio_data_t;

  // The per-entry timer lives beside this struct because its width is an
  // instance parameter of the tracker.
  typedef struct packed {
    logic        active;
    ccip_tid_t   tid;
    ccip_index_t index;
  } mmioread_track_t;

endpackage

// File: rtl/mmio_rdrsp_tracker_if.sv
// MMIO read request / response / report bundle between the host-side
// emulator and the read-response tracker.
interface mmio_rdrsp_tracker_if;
  import ase_pkg::*;

  logic            req_valid;
  ccip_tid_t       req_tid;
  ccip_index_t     req_index;
  logic            req_ready;

  logic            rsp_valid;
  ccip_tid_t       rsp_tid;
  ccip_mmio_data_t rsp_data;

  logic            out_valid;
  ccip_tid_t       out_tid;
  ccip_index_t     out_index;
  ccip_mmio_data_t out_data;

  logic            timeout_valid;
  ccip_tid_t       timeout_tid;
  ccip_index_t     timeout_index;

  logic            unexp_valid;
  ccip_tid_t       unexp_tid;
  logic            dup_valid;

  modport master (
    output req_valid, req_tid, req_index, rsp_valid, rsp_tid, rsp_data,
    input  req_ready, out_valid, out_tid, out_index, out_data,
           timeout_valid, timeout_tid, timeout_index,
           unexp_valid, unexp_tid, dup_valid
  );

  modport slave (
    input  req_valid, req_tid, req_index, rsp_valid, rsp_tid, rsp_data,
    output req_ready, out_valid, out_tid, out_index, out_data,
           timeout_valid, timeout_tid, timeout_index,
           unexp_valid, unexp_tid, dup_valid
  );

endinterface

// File: rtl/ase_ffs_encoder.sv
// Lowest-set-bit priority encoder: returns the index of the lowest set bit
// of vec and whether any bit was set.
module ase_ffs_encoder #(
  parameter int WIDTH = 4,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    // NOTE: defaults are assigned before the loop so every path drives both
    // outputs; without them this block would infer latches.
    idx   = '0;
    found = 1'b0;
    // Scanning from the top down lets the lowest set bit write last and win.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_rdrsp_tracker.sv
// Tracks outstanding MMIO reads by tid, matches AFU read responses back to
// their register index, and reports timeouts, unexpected and duplicate tids.
module mmio_rdrsp_tracker
  import ase_pkg::*;
#(
  parameter int NUM_ENTRIES    = 4,
  parameter int TIMEOUT_CYCLES = 512,
  parameter int TIMER_W        = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  mmio_rdrsp_tracker_if.slave                bus,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   outstanding
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int CNT_W = $clog2(NUM_ENTRIES + 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES);

  mmioread_track_t        entries [NUM_ENTRIES];
  logic [TIMER_W-1:0]     timers  [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] active;
  logic [NUM_ENTRIES-1:0] dup_vec;
  logic [NUM_ENTRIES-1:0] hit_vec;
  logic [NUM_ENTRIES-1:0] expired_vec;
  logic [NUM_ENTRIES-1:0] free_vec;
  logic [NUM_ENTRIES-1:0] active_next;

  logic                   accept;
  logic                   dup;
  logic                   do_alloc;
  logic [IDX_W-1:0]       alloc_idx;
  logic [IDX_W-1:0]       match_idx;
  logic [IDX_W-1:0]       exp_idx;
  logic                   alloc_found;
  logic                   match_found;
  logic                   exp_found;

  // Per-entry compares against the pre-edge entry state.
  always_comb begin
    active      = '0;
    dup_vec     = '0;
    hit_vec     = '0;
    expired_vec = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      active[i]      = entries[i].active;
      dup_vec[i]     = entries[i].active && (entries[i].tid == bus.req_tid);
      hit_vec[i]     = bus.rsp_valid && entries[i].active &&
                       (entries[i].tid == bus.rsp_tid);
      // A response to an expired entry takes precedence over its timeout.
      expired_vec[i] = entries[i].active && (timers[i] == TIMER_MAX) &&
                       !hit_vec[i];
    end
  end

  assign bus.req_ready = ~&active;
  assign accept        = bus.req_valid && bus.req_ready;
  assign dup           = accept && (|dup_vec);
  assign do_alloc      = accept && !(|dup_vec) && alloc_found;

  ase_ffs_encoder #(.WIDTH(NUM_ENTRIES), .IDX_W(IDX_W)) u_alloc_enc (
    .vec   (~active),
    .idx   (alloc_idx),
    .found (alloc_found)
  );

  ase_ffs_encoder #(.WIDTH(NUM_ENTRIES), .IDX_W(IDX_W)) u_match_enc (
    .vec   (hit_vec),
    .idx   (match_idx),
    .found (match_found)
  );

  ase_ffs_encoder #(.WIDTH(NUM_ENTRIES), .IDX_W(IDX_W)) u_expire_enc (
    .vec   (expired_vec),
    .idx   (exp_idx),
    .found (exp_found)
  );

  // Allocation only ever targets an entry that is free before this edge, so
  // it never collides with an entry being released in the same cycle.
  always_comb begin
    free_vec    = '0;
    active_next = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      free_vec[i]    = (match_found && (match_idx == IDX_W'(i))) ||
                       (exp_found   && (exp_idx   == IDX_W'(i)));
      active_next[i] = (active[i] && !free_vec[i]) ||
                       (do_alloc && (alloc_idx == IDX_W'(i)));
    end
  end

  // NOTE: the whole tracking array, payload included, is reset; it is only a
  // handful of entries and a clean payload keeps post-reset state deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entries[i] <= '0;
        timers[i]  <= '0;
      end
    end else begin
      // NOTE: non-blocking updates so every entry is computed from the
      // pre-edge state of all entries, independent of loop order.
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entries[i].active <= active_next[i];
        if (do_alloc && (alloc_idx == IDX_W'(i))) begin
          entries[i].tid   <= bus.req_tid;
          entries[i].index <= bus.req_index;
          timers[i]        <= '0;
        end else if (free_vec[i]) begin
          timers[i] <= '0;
        end else if (active[i] && (timers[i] != TIMER_MAX)) begin
          timers[i] <= timers[i] + 1'b1;
        end
      end
    end
  end

  // Registered report outputs; payload fields hold between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid     <= 1'b0;
      bus.out_tid       <= '0;
      bus.out_index     <= '0;
      bus.out_data      <= '0;
      bus.timeout_valid <= 1'b0;
      bus.timeout_tid   <= '0;
      bus.timeout_index <= '0;
      bus.unexp_valid   <= 1'b0;
      bus.unexp_tid     <= '0;
      bus.dup_valid     <= 1'b0;
      outstanding       <= '0;
    end else begin
      bus.out_valid <= match_found;
      if (match_found) begin
        bus.out_tid   <= bus.rsp_tid;
        bus.out_index <= entries[match_idx].index;
        bus.out_data  <= bus.rsp_data;
      end

      bus.timeout_valid <= exp_found;
      if (exp_found) begin
        bus.timeout_tid   <= entries[exp_idx].tid;
        bus.timeout_index <= entries[exp_idx].index;
      end

      bus.unexp_valid <= bus.rsp_valid && !match_found;
      if (bus.rsp_valid && !match_found) begin
        bus.unexp_tid <= bus.rsp_tid;
      end

      bus.dup_valid <= dup;
      outstanding   <= CNT_W'($countones(active_next));
    end
  end

endmodule

// File: tb/tb_mmio_rdrsp_tracker.sv
// Randomised self-checking bench for mmio_rdrsp_tracker: a slot-list
// reference model predicts every registered output each cycle.
module tb_mmio_rdrsp_tracker;
  import ase_pkg::*;

  localparam int N = 4;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] outstanding;

  mmio_rdrsp_tracker_if bus ();

  mmio_rdrsp_tracker #(
    .NUM_ENTRIES    (N),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .outstanding (outstanding)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: slot list with age counters.
  bit          m_used  [N];
  logic [8:0]  m_tid   [N];
  logic [15:0] m_index [N];
  int          m_age   [N];

  logic        e_ready;
  logic        e_out_valid, e_to_valid, e_unexp_valid, e_dup;
  logic [8:0]  e_out_tid, e_to_tid, e_unexp_tid;
  logic [15:0] e_out_index, e_to_index;
  logic [63:0] e_out_data;
  logic [2:0]  e_count;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int s = 0; s < N; s++) begin
      m_used[s] = 1'b0;
      m_age[s]  = 0;
    end
    e_ready = 1'b1;
    e_out_valid = 1'b0; e_to_valid = 1'b0; e_unexp_valid = 1'b0; e_dup = 1'b0;
    e_out_tid = '0; e_to_tid = '0; e_unexp_tid = '0;
    e_out_index = '0; e_to_index = '0; e_out_data = '0;
    e_count = '0;
  endtask

  task automatic compare_all();
    check("req_ready", 64'(bus.req_ready), 64'(e_ready));
    check("out_valid", 64'(bus.out_valid), 64'(e_out_valid));
    if (e_out_valid) begin
      check("out_tid",   64'(bus.out_tid),   64'(e_out_tid));
      check("out_index", 64'(bus.out_index), 64'(e_out_index));
      check("out_data",  bus.out_data,       e_out_data);
    end
    check("timeout_valid", 64'(bus.timeout_valid), 64'(e_to_valid));
    if (e_to_valid) begin
      check("timeout_tid",   64'(bus.timeout_tid),   64'(e_to_tid));
      check("timeout_index", 64'(bus.timeout_index), 64'(e_to_index));
    end
    check("unexp_valid", 64'(bus.unexp_valid), 64'(e_unexp_valid));
    if (e_unexp_valid) check("unexp_tid", 64'(bus.unexp_tid), 64'(e_unexp_tid));
    check("dup_valid",   64'(bus.dup_valid),   64'(e_dup));
    check("outstanding", 64'(outstanding),     64'(e_count));
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic cycle(input bit rv, input logic [8:0] rt, input logic [15:0] ri,
                       input bit sv, input logic [8:0] st, input logic [63:0] sd);
    int  hit, exp_s, alloc, cnt;
    bit  full, dup;
    bus.req_valid = rv; bus.req_tid = rt; bus.req_index = ri;
    bus.rsp_valid = sv; bus.rsp_tid = st; bus.rsp_data  = sd;

    full = 1'b1; hit = -1; exp_s = -1; alloc = -1; dup = 1'b0;
    for (int s = 0; s < N; s++) if (!m_used[s]) full = 1'b0;
    for (int s = 0; s < N; s++) begin
      if (m_used[s] && sv && m_tid[s] == st) hit = s;
      if (m_used[s] && rv && !full && m_tid[s] == rt) dup = 1'b1;
      if (!m_used[s] && alloc < 0) alloc = s;
      if (m_used[s] && m_age[s] == T && s != hit && exp_s < 0) exp_s = s;
    end
    // hit is final only after the loop; redo expiry selection with it known.
    exp_s = -1;
    for (int s = 0; s < N; s++)
      if (m_used[s] && m_age[s] == T && s != hit && exp_s < 0) exp_s = s;

    e_out_valid = (hit >= 0);
    if (hit >= 0) begin
      e_out_tid = st; e_out_index = m_index[hit]; e_out_data = sd;
    end
    e_unexp_valid = sv && (hit < 0);
    if (sv && hit < 0) e_unexp_tid = st;
    e_to_valid = (exp_s >= 0);
    if (exp_s >= 0) begin
      e_to_tid = m_tid[exp_s]; e_to_index = m_index[exp_s];
    end
    e_dup = dup;

    for (int s = 0; s < N; s++) if (m_used[s] && m_age[s] < T) m_age[s]++;
    if (hit >= 0)   m_used[hit]   = 1'b0;
    if (exp_s >= 0) m_used[exp_s] = 1'b0;
    if (rv && !full && !dup) begin
      m_used[alloc] = 1'b1; m_tid[alloc] = rt; m_index[alloc] = ri; m_age[alloc] = 0;
    end
    cnt = 0;
    for (int s = 0; s < N; s++) if (m_used[s]) cnt++;
    e_count = 3'(cnt);
    e_ready = (cnt < N);

    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    cycle(1'b0, 9'h0, 16'h0, 1'b0, 9'h0, 64'h0);
  endtask

  task automatic req(input logic [8:0] t, input logic [15:0] i);
    cycle(1'b1, t, i, 1'b0, 9'h0, 64'h0);
  endtask

  task automatic rsp(input logic [8:0] t, input logic [63:0] d);
    cycle(1'b0, 9'h0, 16'h0, 1'b1, t, d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req_valid = 1'b0; bus.req_tid = '0; bus.req_index = '0;
    bus.rsp_valid = 1'b0; bus.rsp_tid = '0; bus.rsp_data  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check("reset_ready_lit", 64'(bus.req_ready), 64'd1);
    rst_n = 1'b1;

    // Single read
    req(9'h005, 16'h0010);
    check("single_outstanding_1", 64'(outstanding), 64'd1);
    repeat (9) idle();
    rsp(9'h005, 64'hDEADBEEF_CAFEF00D);
    check("single_out_valid", 64'(bus.out_valid), 64'd1);
    check("single_out_index", 64'(bus.out_index), 64'h0010);
    check("single_out_data", bus.out_data, 64'hDEADBEEF_CAFEF00D);
    check("single_outstanding_0", 64'(outstanding), 64'd0);

    // Fill and backpressure
    for (int k = 1; k <= 4; k++) req(9'(k), 16'(16'h0100 + k));
    check("fill_ready_low", 64'(bus.req_ready), 64'd0);
    req(9'h005, 16'h0105);
    check("fill_5th_ignored", 64'(outstanding), 64'd4);
    rsp(9'h003, 64'h3333);
    check("fill_ready_back", 64'(bus.req_ready), 64'd1);
    check("fill_rsp3_index", 64'(bus.out_index), 64'h0103);
    req(9'h020, 16'h0120);
    check("fill_refill", 64'(outstanding), 64'd4);
    rsp(9'h001, 64'h1); rsp(9'h002, 64'h2); rsp(9'h004, 64'h4); rsp(9'h020, 64'h20);
    check("fill_drained", 64'(outstanding), 64'd0);

    // Timeout
    req(9'h01A, 16'h0055);
    n = 0;
    while (n < 40 && !bus.timeout_valid) begin
      idle();
      n++;
    end
    check("timeout_latency", 64'(n), 64'd17);
    check("timeout_tid_lit", 64'(bus.timeout_tid), 64'h01A);
    check("timeout_freed", 64'(outstanding), 64'd0);
    rsp(9'h01A, 64'hAAAA);
    check("late_rsp_unexp", 64'(bus.unexp_valid), 64'd1);

    // Response in the same cycle the timer saturates
    req(9'h007, 16'h0077);
    repeat (16) idle();
    rsp(9'h007, 64'h7777);
    check("race_out_valid", 64'(bus.out_valid), 64'd1);
    check("race_no_timeout", 64'(bus.timeout_valid), 64'd0);
    idle();
    check("race_no_late_timeout", 64'(bus.timeout_valid), 64'd0);

    // Duplicate and unexpected
    req(9'h009, 16'h0099);
    req(9'h009, 16'h0098);
    check("dup_valid_lit", 64'(bus.dup_valid), 64'd1);
    check("dup_outstanding", 64'(outstanding), 64'd1);
    rsp(9'h1FF, 64'h0);
    check("unexp_valid_lit", 64'(bus.unexp_valid), 64'd1);
    check("unexp_tid_lit", 64'(bus.unexp_tid), 64'h1FF);
    rsp(9'h009, 64'h9);
    check("dup_kept_first", 64'(bus.out_index), 64'h0099);

    // Request and response with the same tid in one cycle: no match
    cycle(1'b1, 9'h011, 16'h0011, 1'b1, 9'h011, 64'h11);
    check("same_cycle_unexp", 64'(bus.unexp_valid), 64'd1);
    rsp(9'h011, 64'h11);

    // Reset mid-flight
    req(9'h031, 16'h0031); req(9'h032, 16'h0032); req(9'h033, 16'h0033); req(9'h034, 16'h0034);
    rsp(9'h031, 64'h31);
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_ready", 64'(bus.req_ready), 64'd1);
    check("rst_timeout_valid", 64'(bus.timeout_valid), 64'd0);
    bus.req_valid = 1'b0; bus.rsp_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    rsp(9'h032, 64'h32);
    check("post_rst_unexp", 64'(bus.unexp_valid), 64'd1);

    // Randomised traffic with a small tid space to provoke hits, dups and timeouts
    for (int c = 0; c < 3000; c++) begin
      cycle(($urandom % 3) == 0, 9'($urandom_range(7, 0)), 16'($urandom),
            ($urandom % 3) == 0, 9'($urandom_range(9, 0)), {$urandom, $urandom});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mmio_rdrsp_tracker.md
# mmio_rdrsp_tracker

Tracks MMIO read requests issued from the host toward the AFU and matches the AFU's read responses back to them by transaction ID (tid). Forwards matched responses with their original register index, enforces a per-request response timeout, and flags unexpected or duplicate tids. Sits in the ASE CCI-P emulator between the MMIO request path (host → AFU, C0 config header) and the AFU MMIO read-response path (AFU → host, C2).

## Interface
**Reset and clocking (already decided):** one clock, `clk`; reset `rst_n` is asynchronous and active-low.

Parameters:
- `NUM_ENTRIES`, default 4: number of outstanding MMIO reads tracked.
- `TIMEOUT_CYCLES`, default 512: cycles an entry waits for a response before timing out.
- `TIMER_W`, default `$clog2(TIMEOUT_CYCLES+1)`: width of each entry timer.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: async active-low reset.
- `req_valid` in 1: new MMIO read request issued to the AFU.
- `req_tid` in 9: request tid.
- `req_index` in 16: MMIO DWORD index.
- `req_ready` out 1: a free entry exists.
- `rsp_valid` in 1: AFU MMIO read response valid.
- `rsp_tid` in 9: response tid.
- `rsp_data` in 64: response data.
- `out_valid` out 1: matched response, 1-cycle pulse.
- `out_tid` out 9: tid of the matched response.
- `out_index` out 16: index of the matched response.
- `out_data` out 64: data of the matched response.
- `timeout_valid` out 1: entry expired, 1-cycle pulse.
- `timeout_tid` out 9: tid of the expired entry.
- `timeout_index` out 16: index of the expired entry.
- `unexp_valid` out 1: response with no active matching tid, pulse.
- `unexp_tid` out 9: tid of the unexpected response.
- `dup_valid` out 1: request whose tid is already active, pulse; the request is not stored.
- `outstanding` out `$clog2(NUM_ENTRIES+1)`: count of active entries.

## Operation
- Entry state is {`tid`, `index`, `timer`, `active`}.
- `req_ready = ~&active`. This is combinational from the current active vector only; a same-cycle free does not raise it.
- **Accept** when `req_valid & req_ready`.
  - If `req_tid` matches an active entry: `dup_valid` pulses and no entry is allocated.
  - Otherwise, allocate the lowest-index free entry with `timer=0`.
- **Timers:** each active entry's timer increments by 1 per cycle and saturates at `TIMEOUT_CYCLES`. An entry whose timer equals `TIMEOUT_CYCLES` is *expired*.
- **Response match:** `rsp_valid` with `rsp_tid` compared against all active entries, including expired ones.
  - Hit: emit `out_*` with the stored index and `rsp_data`, and free that entry.
  - Miss: `unexp_valid` pulses with `rsp_tid`.
- **Timeout report:** each cycle, the lowest-index expired entry that is not being matched by a response this cycle is reported on `timeout_*` and freed. At most one report per cycle; other expired entries wait.
- **Simultaneous events:**
  - A response match and a timeout report on the same entry: the response wins.
  - A response and a timeout on different entries: both are serviced.
  - Allocation and free in the same cycle: allocation uses the pre-free free vector; the freed entry becomes available next cycle.
  - A response arriving in the same cycle a request with that tid is accepted does not match the new entry.
- `outstanding` equals `popcount(active)` and is registered.

## Timing
- All outputs except `req_ready` are registered.
- Reset value is 0 for all outputs, all `active` bits, and all timers. `req_ready` is 1 after reset.
- Request accepted in cycle t → entry active at t+1 with timer 0 → expires when its timer reaches `TIMEOUT_CYCLES`, i.e. in cycle t+1+`TIMEOUT_CYCLES` at the earliest. The `timeout_valid` pulse appears the following cycle.
- Response in cycle t → `out_valid` or `unexp_valid` at t+1.
- A request accepted at cycle t produces `dup_valid` at t+1 when its tid is already active.
- Reset assertion mid-operation clears all entries immediately. In-flight pulses are dropped, and responses arriving later are reported as unexpected.

## Structure
- The entry struct is `mmioread_track_t` and the tid/index widths are `CCIP_CFGHDR_TID_WIDTH` and `CCIP_CFGHDR_INDEX_WIDTH`. All of these live in `ase_pkg`; the timer width comes from `TIMER_W` here.
- One sub-module: `ase_ffs_encoder` (parameterised lowest-set-bit priority encoder returning index + found). It is used three times: free-slot allocation, response match, and expired-entry selection.

## Test plan
- **Single read:** req tid=0x005, index=0x0010; response tid=0x005, data=0xDEADBEEF_CAFEF00D 10 cycles later → `out_valid` one cycle after the response with index 0x0010 and that data; `outstanding` goes 0→1→0.
- **Fill and backpressure:** 4 reqs tids 1..4 → `req_ready`=0. A 5th `req_valid` is ignored. Response tid=3 → `req_ready`=1 next cycle, and the next request allocates entry 2.
- **Timeout:** `TIMEOUT_CYCLES`=16, req tid=0x1A at t → `timeout_valid` with tid 0x1A at t+18, entry freed. A later response tid=0x1A → `unexp_valid`.
- **Race:** response for tid 7 arrives in the exact cycle its timer hits `TIMEOUT_CYCLES` → `out_valid` only, no `timeout_valid`.
- **Duplicate/unexpected:** two reqs with tid 9 → second yields `dup_valid`, `outstanding`=1. Response tid 0x1FF → `unexp_valid` with `unexp_tid`=0x1FF.
- **Reset mid-flight:** 3 active entries, assert `rst_n`=0 for 1 cycle → all outputs 0, `outstanding`=0, `req_ready`=1.
